md_k2h_packer: RTL

MD_K2H_PACKER -- requirements
Module: md_k2h_packer

---
 rtl/md_k2h_packer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/md_k2h_packer.sv
// md_k2h_packer
//   Packs 192-bit particle records from the MD core into 512-bit AXI-Stream
//   beats, two records per beat, for the kernel-to-host stream. A packet is
//   started by a one-cycle start pulse carrying the record count and TDEST.
//   The final beat of a packet is flagged with tlast and may carry only one
//   record; done pulses for one cycle once the packet is complete.
//
// Ports
//   ap_clk, ap_rst        clock, synchronous active-high reset
//   start                 one-cycle packet start (ignored unless idle)
//   num_records, dest     record count and TDEST, sampled on start
//   rec_tdata/tvalid/tready   upstream record stream
//   M_AXIS_k2h_*          downstream AXI-Stream master
//   busy, done            status: not idle / one-cycle completion pulse
//   beat_count            output handshake counter (only with MD_PACK_STATS_EN)
//
// Build option
//   MD_PACK_STATS_EN      adds the saturating beat_count output
module md_k2h_packer #(
  parameter int AXIS_TDATA_WIDTH      = 512,
  parameter int REC_WIDTH             = 192,
  parameter int STREAMING_TDEST_WIDTH = 16
) (
  input  logic                               ap_clk,
  input  logic                               ap_rst,
  input  logic                               start,
  input  logic [31:0]                        num_records,
  input  logic [STREAMING_TDEST_WIDTH-1:0]   dest,
  input  logic [REC_WIDTH-1:0]               rec_tdata,
  input  logic                               rec_tvalid,
  output logic                               rec_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]        M_AXIS_k2h_tdata,
  output logic [AXIS_TDATA_WIDTH/8-1:0]      M_AXIS_k2h_tkeep,
  output logic                               M_AXIS_k2h_tvalid,
  output logic                               M_AXIS_k2h_tlast,
  output logic [STREAMING_TDEST_WIDTH-1:0]   M_AXIS_k2h_tdest,
  input  logic                               M_AXIS_k2h_tready,
  output logic                               busy,
`ifdef MD_PACK_STATS_EN
  output logic [31:0]                        beat_count,
`endif
  output logic                               done
);

  localparam int KEEP_W = AXIS_TDATA_WIDTH / 8;
  localparam int REC_B  = REC_WIDTH / 8;
  localparam int PAD_W  = AXIS_TDATA_WIDTH - 2 * REC_WIDTH;

  localparam logic [KEEP_W-1:0] KEEP_ONE = {{(KEEP_W - REC_B){1'b0}}, {REC_B{1'b1}}};
  localparam logic [KEEP_W-1:0] KEEP_TWO = {{(KEEP_W - 2 * REC_B){1'b0}}, {(2 * REC_B){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_SEND    = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  state_t                           state_q, state_d;
  logic [31:0]                      remaining_q, remaining_d;
  logic [STREAMING_TDEST_WIDTH-1:0] dest_q, dest_d;
  logic [REC_WIDTH-1:0]             rec0_q, rec0_d;
  logic [REC_WIDTH-1:0]             rec1_q, rec1_d;
  logic [1:0]                       cnt_q, cnt_d;   // records held in the slot buffer

  logic rec_accept;
  logic beat_hs;

  assign rec_accept = rec_tvalid && (state_q == S_COLLECT);
  assign beat_hs    = M_AXIS_k2h_tready && (state_q == S_SEND);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      dest_q      <= '0;
      rec0_q      <= '0;
      rec1_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      dest_q      <= dest_d;
      rec0_q      <= rec0_d;
      rec1_q      <= rec1_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = (num_records == 32'd0) ? S_FINISH : S_COLLECT;
      // Leave as soon as the beat is full or the packet has no records left.
      S_COLLECT: if (rec_accept && (cnt_q == 2'd1 || remaining_q == 32'd1)) state_d = S_SEND;
      S_SEND:    if (M_AXIS_k2h_tready) state_d = (remaining_q == 32'd0) ? S_FINISH : S_COLLECT;
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    remaining_d = remaining_q;
    dest_d      = dest_q;
    rec0_d      = rec0_q;
    rec1_d      = rec1_q;
    cnt_d       = cnt_q;
    if (state_q == S_IDLE && start && num_records != 32'd0) begin
      remaining_d = num_records;
      dest_d      = dest;
      rec0_d      = '0;
      rec1_d      = '0;
      cnt_d       = '0;
    end else if (rec_accept) begin
      if (cnt_q == 2'd0) rec0_d = rec_tdata;
      else               rec1_d = rec_tdata;
      cnt_d       = cnt_q + 2'd1;
      remaining_d = remaining_q - 32'd1;
    end else if (beat_hs && remaining_q != 32'd0) begin
      // Clearing the upper slot keeps a trailing single-record beat zero-padded.
      rec0_d = '0;
      rec1_d = '0;
      cnt_d  = '0;
    end
  end

  always_comb begin
    rec_tready        = (state_q == S_COLLECT);
    M_AXIS_k2h_tvalid = (state_q == S_SEND);
    M_AXIS_k2h_tlast  = (state_q == S_SEND) && (remaining_q == 32'd0);
    M_AXIS_k2h_tdata  = {{PAD_W{1'b0}}, rec1_q, rec0_q};
    M_AXIS_k2h_tdest  = dest_q;
    busy              = (state_q != S_IDLE);
    done              = (state_q == S_FINISH);
    case (cnt_q)
      2'd1:    M_AXIS_k2h_tkeep = KEEP_ONE;
      2'd2:    M_AXIS_k2h_tkeep = KEEP_TWO;
      default: M_AXIS_k2h_tkeep = '0;
    endcase
  end

`ifdef MD_PACK_STATS_EN
  logic [31:0] beat_count_q, beat_count_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    beat_count_d = beat_hs ? sat_inc(beat_count_q) : beat_count_q;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) beat_count_q <= '0;
    else        beat_count_q <= beat_count_d;
  end

  assign beat_count = beat_count_q;
`endif

endmodule
